// File: rtl/lin_seq_pkg.sv
// lin_seq_pkg: shared types and reset-seed helper for the linear-recurrence generator.
package lin_seq_pkg;
    localparam int MAX_ORDER = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Reset seed is 0,1,1,...: only hist[0] starts at zero.
    function automatic logic reset_term_lsb(int i);
        return i != 0;
    endfunction
endpackage

// File: rtl/lin_seq_gen_if.sv
// lin_seq_gen_if: control, seed and term-stream signals of the sequence generator.
interface lin_seq_gen_if #(
    parameter int WIDTH = 32,
    parameter int ORDER = 2,
    parameter int CNT_W = 16
) ();
    logic                   load_i;
    logic [ORDER*WIDTH-1:0] seed_i;
    logic                   start_i;
    logic [CNT_W-1:0]       len_i;
    logic                   seq_ready_i;
    logic                   seq_valid_o;
    logic [WIDTH-1:0]       seq_o;
    logic [CNT_W-1:0]       idx_o;
    logic                   done_o;
    logic                   ovf_o;
    modport master (
        input  load_i, seed_i, start_i, len_i, seq_ready_i,
        output seq_valid_o, seq_o, idx_o, done_o, ovf_o
    );
    modport slave (
        output load_i, seed_i, start_i, len_i, seq_ready_i,
        input  seq_valid_o, seq_o, idx_o, done_o, ovf_o
    );
endinterface

// File: rtl/lin_seq_adder.sv
// lin_seq_adder: masked sum of history taps with carry detect.
// `LIN_SEQ_GEN_SAT_EN clamps an overflowing sum to all-ones instead of wrapping.
module lin_seq_adder #(
    parameter int WIDTH = 32,
    parameter int ORDER = 2,
    parameter logic [ORDER-1:0] TAP_MASK = '1
) (
    input  logic [ORDER-1:0][WIDTH-1:0] hist,
    output logic [WIDTH-1:0]            sum,
    output logic                        ovf
);
    localparam int EW = WIDTH + $clog2(ORDER);
    logic [EW-1:0] acc;
    always_comb begin
        acc = '0;
        for (int i = 0; i < ORDER; i++)
            if (TAP_MASK[i]) acc = acc + EW'(hist[i]);
        ovf = |acc[EW-1:WIDTH];
`ifdef LIN_SEQ_GEN_SAT_EN
        sum = ovf ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
`else
        sum = acc[WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/lin_seq_gen.sv
// lin_seq_gen: ORDER-deep linear-recurrence generator emitting len_i terms on a valid/ready stream.
// Optional `LIN_SEQ_GEN_SAT_EN saturates overflowing terms (handled in lin_seq_adder).
module lin_seq_gen
    import lin_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ORDER = 2,
    parameter logic [ORDER-1:0] TAP_MASK = '1,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset_n,
    lin_seq_gen_if.master bus
);
    state_t                      state, state_nx;
    logic [ORDER-1:0][WIDTH-1:0] hist;
    logic [CNT_W-1:0]            idx, len_q;
    logic                        ovf_q, accept, last, add_ovf;
    logic [WIDTH-1:0]            next_term;

    lin_seq_adder #(.WIDTH(WIDTH), .ORDER(ORDER), .TAP_MASK(TAP_MASK)) u_adder (
        .hist(hist),
        .sum (next_term),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;

    // load_i outranks start and accept, so it is tested before any state arc.
    always_comb begin
        accept   = state == RUN && bus.seq_ready_i;
        last     = idx == len_q - CNT_W'(1);
        state_nx = bus.load_i        ? IDLE :
                   state == IDLE     ? (bus.start_i ? (bus.len_i == '0 ? DONE : RUN) : IDLE) :
                   state == RUN      ? (accept && last ? DONE : RUN) :
                                       IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ORDER; i++) hist[i] <= {{(WIDTH-1){1'b0}}, reset_term_lsb(i)};
            idx   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.load_i) begin
            hist  <= bus.seed_i;
            idx   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.start_i) begin
                len_q <= bus.len_i;
                idx   <= '0;
                ovf_q <= 1'b0;
            end
            if (accept) begin
                hist <= {next_term, hist[ORDER-1:1]};
                idx  <= idx + CNT_W'(1);
                if (add_ovf) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.seq_valid_o = state == RUN;
    assign bus.done_o      = state == DONE;
    assign bus.seq_o       = hist[0];
    assign bus.idx_o       = idx;
    assign bus.ovf_o       = ovf_q;
endmodule
